// File: rtl/quant_pkg.sv
// quant_pkg: shared state encoding and default widths for the quantdeser block
package quant_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} quantdeser_state_t;
  localparam int BDOUT_DEF = 32;
  localparam int BDINMAX_DEF = 32;
endpackage

// File: rtl/quantdeser_align.sv
// quantdeser_align: places a received word so its MSB lands at msbidx_i, optional sign fill
// Ports: val_i (received bits, LSB-aligned), msbidx_i (target MSB position),
//        bdin_i (received precision minus one), sgn_i (sign-fill request),
//        dout_o (aligned word).
// Sign fill above msbidx_i only exists when QUANTDESER_SIGNEXT_EN is defined.
module quantdeser_align
  import quant_pkg::*;
#(
  parameter int BDOUT   = BDOUT_DEF,
  parameter int BDINMAX = BDINMAX_DEF,
  localparam int MAXBDOP = $clog2(BDOUT),
  localparam int MAXBDIP = $clog2(BDINMAX)
) (
  input  logic [BDINMAX-1:0] val_i,
  input  logic [MAXBDOP-1:0] msbidx_i,
  input  logic [MAXBDIP-1:0] bdin_i,
  input  logic               sgn_i,
  output logic [BDOUT-1:0]   dout_o
);
  logic [BDOUT-1:0] ext;
  logic [BDOUT-1:0] shifted;
  logic [MAXBDOP:0] m;
  logic [MAXBDOP:0] b;
  assign ext = BDOUT'(val_i);
  assign m = {1'b0, msbidx_i};
  assign b = (MAXBDOP+1)'(bdin_i);
  // bits above the received MSB are already zero, so the shift alone zero-fills above msbidx
  assign shifted = (m >= b) ? ext << (m - b) : ext >> (b - m);
`ifdef QUANTDESER_SIGNEXT_EN
  logic [BDOUT-1:0] fill;
  assign fill = {BDOUT{sgn_i & val_i[bdin_i]}} << msbidx_i << 1;
  assign dout_o = shifted | fill;
`else
  logic unused_sgn;
  assign unused_sgn = sgn_i;
  assign dout_o = shifted;
`endif
endmodule

// File: rtl/quantdeser.sv
// quantdeser: serial MSB-first deserializer with configurable precision and output alignment
// Ports: clk, rst_n (async active-low), clr (sync clear), msbidx (dout bit for received MSB),
//        bdin (precision minus one), start (begin a word), sgn (sign-fill request),
//        din (serial data), dout (aligned word), dout_valid (one-cycle strobe), busy (in SHIFT).
// Optional sign extension is enabled by defining QUANTDESER_SIGNEXT_EN.
module quantdeser
  import quant_pkg::*;
#(
  parameter int BDOUT   = BDOUT_DEF,
  parameter int BDINMAX = BDINMAX_DEF,
  localparam int MAXBDOP = $clog2(BDOUT),
  localparam int MAXBDIP = $clog2(BDINMAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [MAXBDOP-1:0] msbidx,
  input  logic [MAXBDIP-1:0] bdin,
  input  logic               start,
  input  logic               sgn,
  input  logic               din,
  output logic [BDOUT-1:0]   dout,
  output logic               dout_valid,
  output logic               busy
);
  quantdeser_state_t  state_q;
  logic [BDINMAX-1:0] sr_q;
  logic [MAXBDIP-1:0] cnt_q;
  logic [MAXBDOP-1:0] msbidx_q;
  logic [MAXBDIP-1:0] bdin_q;
  logic               sgn_q;
  logic [BDOUT-1:0]   dout_q;
  logic [BDOUT-1:0]   dout_d;
  logic               dout_valid_q;
  logic               busy_q;
  quantdeser_align #(.BDOUT(BDOUT), .BDINMAX(BDINMAX)) u_align (
    .val_i(sr_q),
    .msbidx_i(msbidx_q),
    .bdin_i(bdin_q),
    .sgn_i(sgn_q),
    .dout_o(dout_d)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      msbidx_q <= '0;
      bdin_q <= '0;
      sgn_q <= 1'b0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      msbidx_q <= '0;
      bdin_q <= '0;
      sgn_q <= 1'b0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          sr_q <= {sr_q[BDINMAX-2:0], din};
          if (cnt_q == bdin_q) begin
            state_q <= DONE;
            busy_q <= 1'b0;
          end else
            cnt_q <= cnt_q + MAXBDIP'(1);
        end
        default: begin
          // DONE publishes the word; a start here chains straight into the next one
          if (state_q == DONE) begin
            dout_q <= dout_d;
            dout_valid_q <= 1'b1;
          end
          if (start) begin
            msbidx_q <= msbidx;
            bdin_q <= bdin;
            sgn_q <= sgn;
            sr_q <= '0;
            cnt_q <= '0;
            state_q <= SHIFT;
            busy_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  assign dout = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_quantdeser.sv
// tb_quantdeser: directed self-checking bench for quantdeser
module tb_quantdeser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  msbidx = '0;
  logic [4:0]  bdin = '0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic        din = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses = 0;
  int          p0;
  quantdeser dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .msbidx(msbidx),
    .bdin(bdin),
    .start(start),
    .sgn(sgn),
    .din(din),
    .dout(dout),
    .dout_valid(dout_valid),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (dout_valid) pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic run_word(input string tag, input int bd, input logic [4:0] msb,
                          input logic [31:0] bits, input logic s, input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1; msbidx = msb; bdin = 5'(bd - 1); sgn = s;
    @(negedge clk);
    msbidx = ~msb; bdin = ~bdin; sgn = ~s;
    for (int i = bd - 1; i >= 0; i--) begin
      din = bits[i];
      start = (i == 0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
    start = 1'b0; din = 1'b0;
    check({tag, "_early_valid"}, 32'(dout_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
    check({tag, "_dout"}, dout, exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(dout_valid), 32'd0);
    check({tag, "_hold"}, dout, exp);
  endtask
  initial begin
    logic [3:0] w1;
    logic [3:0] w2;
    w1 = 4'b1010; w2 = 4'b0110;
    #12;
    check("rst_dout", dout, 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_word("bd1", 1, 5'd0, 32'h1, 1'b0, 32'h0000_0001);
    run_word("bd2_m3", 2, 5'd3, 32'h3, 1'b0, 32'h0000_000C);
    run_word("bd2_m31", 2, 5'd31, 32'h3, 1'b0, 32'hC000_0000);
    run_word("bd32", 32, 5'd31, 32'h5, 1'b0, 32'h0000_0005);
    run_word("bd32_raw", 32, 5'd31, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    run_word("rshift", 8, 5'd3, 32'hB7, 1'b0, 32'h0000_000B);
    run_word("sx_off", 4, 5'd7, 32'hA, 1'b0, 32'h0000_00A0);
`ifdef QUANTDESER_SIGNEXT_EN
    run_word("sx_on", 4, 5'd7, 32'hA, 1'b1, 32'hFFFF_FFA0);
`else
    run_word("sx_ign", 4, 5'd7, 32'hA, 1'b1, 32'h0000_00A0);
`endif
    // back-to-back words, second start issued while in DONE
    p0 = pulses;
    @(negedge clk);
    start = 1'b1; msbidx = 5'd3; bdin = 5'd3; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 3; i >= 0; i--) begin din = w1[i]; @(negedge clk); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_valid1", 32'(dout_valid), 32'd1);
    check("b2b_dout1", dout, 32'hA);
    check("b2b_busy", 32'(busy), 32'd1);
    for (int i = 3; i >= 0; i--) begin din = w2[i]; @(negedge clk); end
    din = 1'b0;
    @(negedge clk);
    check("b2b_valid2", 32'(dout_valid), 32'd1);
    check("b2b_dout2", dout, 32'h6);
    @(negedge clk);
    check("b2b_pulses", 32'(pulses - p0), 32'd2);
    // async reset in the middle of a bd=8 word
    p0 = pulses;
    @(negedge clk);
    start = 1'b1; msbidx = 5'd7; bdin = 5'd7;
    @(negedge clk);
    start = 1'b0; din = 1'b1;
    @(negedge clk); din = 1'b0;
    @(negedge clk); din = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 32'd0);
    check("arst_valid", 32'(dout_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin din = ~din; @(negedge clk); end
    check("arst_idle_busy", 32'(busy), 32'd0);
    check("arst_no_pulse", 32'(pulses - p0), 32'd0);
    run_word("after_rst", 8, 5'd7, 32'h5A, 1'b0, 32'h0000_005A);
    // synchronous clear mid-word
    p0 = pulses;
    @(negedge clk);
    start = 1'b1; msbidx = 5'd7; bdin = 5'd7;
    @(negedge clk);
    start = 1'b0; din = 1'b1;
    @(negedge clk);
    check("clr_pre_dout", dout, 32'h5A);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_dout", dout, 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("clr_no_pulse", 32'(pulses - p0), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
